wb_interconnect: RTL and testbench

//  Single-master Wishbone (pipelined) interconnect between the cpu core and the SoC slaves.

---
 rtl/wb_interconnect.sv | 187 ++++++++++++++++++
 tb/tb_wb_interconnect.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_interconnect.sv
// Single-master pipelined Wishbone interconnect: bootrom / internal RAM / UART.
// Decodes each accepted strobe, routes cyc/stb to the addressed slave, muxes
// ack/stall/data back to the master, and turns unmapped accesses and silent
// slaves into a single-cycle bus error. One transaction outstanding at a time.
module wb_interconnect #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_m_cyc,
  input  logic        i_m_stb,
  input  logic        i_m_we,
  input  logic [31:0] i_m_addr,
  input  logic [31:0] i_m_data,
  output logic [31:0] o_m_data,
  output logic        o_m_ack,
  output logic        o_m_err,
  output logic        o_m_stall,
  output logic [2:0]  o_s_cyc,
  output logic [2:0]  o_s_stb,
  output logic        o_s_we,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_data,
  input  logic [95:0] i_s_data,
  input  logic [2:0]  i_s_ack,
  input  logic [2:0]  i_s_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TIMER_LIM = TIMEOUT_W'(TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] TIMER_MAX = {TIMEOUT_W{1'b1}};

  // Registered state
  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 m_ack_q, m_ack_d;
  logic                 m_err_q, m_err_d;
  logic [31:0]          m_data_q, m_data_d;

  // Combinational decode / routing
  logic [2:0]  hit;
  logic [1:0]  hit_idx;
  logic        hit_any;
  logic [2:0]  sel_oh;
  logic        sel_ack;
  logic [31:0] sel_data;
  logic        req;
  logic        hit_stall;
  logic [2:0]  s_cyc;
  logic [2:0]  s_stb;
  logic        m_stall;

  // Upper bits of the UART data lane carry nothing; only [71:64] is meaningful.
  logic unused_sdata;
  assign unused_sdata = ^i_s_data[95:72];

  // Address decode of the current master address into a one-hot slave hit.
  always_comb begin
    hit     = 3'b000;
    hit[0]  = (i_m_addr[31:15] == 17'h16000);  // 0xb000_0000 .. 0xb000_7fff
    hit[1]  = (i_m_addr[31:15] == 17'h16001);  // 0xb000_8000 .. 0xb000_ffff
    hit[2]  = (i_m_addr[31:16] == 16'hc000);   // 0xc000_0000 .. 0xc000_ffff
    hit_any = |hit;
    hit_idx = 2'd0;
    if (hit[1]) hit_idx = 2'd1;
    if (hit[2]) hit_idx = 2'd2;
  end

  // Response mux for the slave latched at accept time.
  always_comb begin
    sel_oh   = 3'b001 << sel_q;
    sel_ack  = |(i_s_ack & sel_oh);
    sel_data = 32'h0;
    case (sel_q)
      2'd0:    sel_data = i_s_data[31:0];
      2'd1:    sel_data = i_s_data[63:32];
      2'd2:    sel_data = {24'h0, i_s_data[71:64]};
      default: sel_data = 32'h0;
    endcase
  end

  // Transaction FSM next-state logic and slave-side strobe routing.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    timer_d   = timer_q;
    m_ack_d   = 1'b0;
    m_err_d   = 1'b0;
    m_data_d  = m_data_q;
    s_cyc     = 3'b000;
    s_stb     = 3'b000;
    m_stall   = 1'b0;
    req       = i_m_cyc & i_m_stb;
    hit_stall = |(hit & i_s_stall);

    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit_any) begin
            // Present the strobe to the addressed slave; its stall is the master's stall.
            s_cyc   = hit;
            s_stb   = hit;
            m_stall = hit_stall;
            if (!hit_stall) begin
              sel_d   = hit_idx;
              timer_d = '0;
              state_d = WAIT;
            end
          end else begin
            // Unmapped: nothing is strobed, the error pulses during the ERR cycle.
            m_err_d = 1'b1;
            state_d = ERR;
          end
        end
      end

      WAIT: begin
        // Keep cyc to the selected slave while the master holds its cycle,
        // and refuse further strobes until the response is delivered.
        m_stall = 1'b1;
        s_cyc   = sel_oh & {3{i_m_cyc}};
        if (!i_m_cyc) begin
          // Master abort wins over a coincident ack or timeout.
          state_d = IDLE;
        end else if (sel_ack) begin
          m_data_d = sel_data;
          m_ack_d  = 1'b1;
          state_d  = IDLE;
        end else if (timer_q == TIMER_LIM) begin
          m_err_d = 1'b1;
          state_d = IDLE;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TIMEOUT_W'(1);
        end
      end

      ERR: begin
        m_stall = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers; reset drops any pending ack/err immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      timer_q  <= '0;
      m_ack_q  <= 1'b0;
      m_err_q  <= 1'b0;
      m_data_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      timer_q  <= timer_d;
      m_ack_q  <= m_ack_d;
      m_err_q  <= m_err_d;
      m_data_q <= m_data_d;
    end
  end

  // Master-facing outputs; strobe routing is forced low while reset is held.
  assign o_m_ack   = m_ack_q;
  assign o_m_err   = m_err_q;
  assign o_m_data  = m_data_q;
  assign o_m_stall = reset ? m_stall : 1'b0;
  assign o_s_cyc   = reset ? s_cyc : 3'b000;
  assign o_s_stb   = reset ? s_stb : 3'b000;

  // Broadcast pass-through to all slaves.
  assign o_s_we    = i_m_we;
  assign o_s_addr  = i_m_addr;
  assign o_s_data  = i_m_data;

endmodule

// File: tb/tb_wb_interconnect.sv
// Randomized bench for wb_interconnect: the bench plays both master and slaves,
// and predicts each transaction's outcome from the address map and the slave's
// behaviour (stall count, ack cycle, abort cycle) at transaction level.
module tb_wb_interconnect;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_m_cyc, i_m_stb, i_m_we;
  logic [31:0] i_m_addr, i_m_data;
  logic [31:0] o_m_data;
  logic        o_m_ack, o_m_err, o_m_stall;
  logic [2:0]  o_s_cyc, o_s_stb;
  logic        o_s_we;
  logic [31:0] o_s_addr, o_s_data;
  logic [95:0] i_s_data;
  logic [2:0]  i_s_ack, i_s_stall;

  wb_interconnect #(.TIMEOUT_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_m_cyc(i_m_cyc), .i_m_stb(i_m_stb), .i_m_we(i_m_we),
    .i_m_addr(i_m_addr), .i_m_data(i_m_data),
    .o_m_data(o_m_data), .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_m_stall(o_m_stall),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data),
    .i_s_data(i_s_data), .i_s_ack(i_s_ack), .i_s_stall(i_s_stall)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        exp_ack, exp_err;
  logic [31:0] exp_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address map as plain address ranges: 0 bootrom, 1 sram, 2 uart, 3 unmapped.
  function automatic int target(input logic [31:0] a);
    if (a >= 32'hb000_0000 && a < 32'hb000_8000) return 0;
    if (a >= 32'hb000_8000 && a < 32'hb001_0000) return 1;
    if (a >= 32'hc000_0000 && a < 32'hc001_0000) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(5, 0))
      0:       return 32'hb000_0000 + ($urandom & 32'h7fff);
      1:       return 32'hb000_8000 + ($urandom & 32'h7fff);
      2:       return 32'hc000_0000 + ($urandom & 32'hffff);
      3:       return 32'hb001_0000 + ($urandom & 32'hffff);
      4:       return 32'hbfff_0000 + ($urandom & 32'hffff);
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_slaves_random();
    i_s_ack   = 3'($urandom);
    i_s_stall = 3'($urandom);
    i_s_data  = {$urandom, $urandom, $urandom};
  endtask

  // Response expected from the previous cycle's edge; ack/err are one-cycle pulses.
  task automatic check_resp();
    chk("m_ack", 128'(o_m_ack), 128'(exp_ack));
    chk("m_err", 128'(o_m_err), 128'(exp_err));
    if (exp_ack) chk("m_data", 128'(o_m_data), 128'(exp_data));
    exp_ack = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic idle_cycle();
    step();
    i_m_cyc  = 1'($urandom);
    i_m_stb  = 1'b0;
    i_m_we   = 1'($urandom);
    i_m_addr = rand_addr();
    i_m_data = $urandom;
    drive_slaves_random();
    #1;
    check_resp();
    chk("idle_stall", 128'(o_m_stall), 128'(0));
    chk("idle_sel", 128'({o_s_cyc, o_s_stb}), 128'(0));
  endtask

  // One master transaction. nstall: cycles the target stalls the strobe;
  // ack_at: WAIT cycle in which the target acks (-1 never); abort_at: WAIT
  // cycle in which the master drops cyc (-1 never).
  task automatic txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                     input int nstall, input int ack_at, input int abort_at,
                     input logic [31:0] sdata);
    int         t;
    logic [2:0] oh;
    bit         done;
    t = target(addr);
    if (t == 3) begin
      step();
      i_m_cyc = 1'b1; i_m_stb = 1'b1; i_m_we = we; i_m_addr = addr; i_m_data = wdata;
      drive_slaves_random();
      #1;
      check_resp();
      chk("miss_stall", 128'(o_m_stall), 128'(0));
      chk("miss_sel", 128'({o_s_cyc, o_s_stb}), 128'(0));
      chk("miss_pass", 128'({o_s_we, o_s_addr, o_s_data}), 128'({we, addr, wdata}));
      exp_err = 1'b1;
      step();
      i_m_stb  = 1'($urandom);
      i_m_addr = rand_addr();
      drive_slaves_random();
      #1;
      check_resp();
      chk("err_stall", 128'(o_m_stall), 128'(1));
      chk("err_stb", 128'(o_s_stb), 128'(0));
      return;
    end
    oh = 3'b001 << t;
    for (int c = 0; c <= nstall; c++) begin
      step();
      i_m_cyc = 1'b1; i_m_stb = 1'b1; i_m_we = we; i_m_addr = addr; i_m_data = wdata;
      drive_slaves_random();
      i_s_stall[t] = (c < nstall);
      #1;
      check_resp();
      chk("req_stall", 128'(o_m_stall), 128'(c < nstall));
      chk("req_sel", 128'({o_s_cyc, o_s_stb}), 128'({oh, oh}));
      chk("req_pass", 128'({o_s_we, o_s_addr, o_s_data}), 128'({we, addr, wdata}));
    end
    done = 1'b0;
    for (int k = 0; !done; k++) begin
      step();
      i_m_cyc  = (k != abort_at);
      i_m_stb  = 1'($urandom);
      i_m_addr = rand_addr();
      drive_slaves_random();
      i_s_ack[t] = (k == ack_at);
      i_s_data[32*t +: 32] = sdata;
      #1;
      check_resp();
      chk("wait_stall", 128'(o_m_stall), 128'(1));
      chk("wait_sel", 128'({o_s_cyc, o_s_stb}), 128'({(k == abort_at) ? 3'b000 : oh, 3'b000}));
      if (k == abort_at) begin
        done = 1'b1;
      end else if (k == ack_at) begin
        exp_ack  = 1'b1;
        exp_data = (t == 2) ? {24'h0, sdata[7:0]} : sdata;
        done     = 1'b1;
      end else if (k == TO) begin
        exp_err = 1'b1;
        done    = 1'b1;
      end
    end
  endtask

  // Reset asserted while a sram read is in WAIT: everything drops at once.
  task automatic reset_mid();
    step();
    i_m_cyc = 1'b1; i_m_stb = 1'b1; i_m_we = 1'b0; i_m_addr = 32'hb000_8010;
    i_s_stall = 3'b000; i_s_ack = 3'b000;
    #1;
    check_resp();
    chk("rm_req", 128'({o_s_cyc, o_s_stb}), 128'(6'b010_010));
    step();
    i_m_stb = 1'b0; i_s_ack = 3'b000;
    #1;
    chk("rm_wait", 128'({o_s_cyc, o_s_stb}), 128'(6'b010_000));
    #1 reset = 1'b0;
    #1;
    chk("rm_cyc", 128'(o_s_cyc), 128'(0));
    chk("rm_data", 128'(o_m_data), 128'(0));
    chk("rm_ack", 128'({o_m_ack, o_m_err}), 128'(0));
    i_s_ack = 3'b010;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_cycle();
    idle_cycle();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nst, ack_at, abort_at;
    reset = 1'b1;
    i_m_cyc = 1'b0; i_m_stb = 1'b0; i_m_we = 1'b0; i_m_addr = 32'h0; i_m_data = 32'h0;
    i_s_data = '0; i_s_ack = 3'b000; i_s_stall = 3'b000;
    exp_ack = 1'b0; exp_err = 1'b0; exp_data = 32'h0;
    #2 reset = 1'b0;
    i_m_cyc = 1'b1; i_m_stb = 1'b1; i_m_we = 1'b1;
    i_m_addr = 32'hb000_8000; i_m_data = 32'hcafe_f00d; i_s_ack = 3'b111;
    @(posedge clk);
    #2;
    chk("rst_ack", 128'(o_m_ack), 128'(0));
    chk("rst_err", 128'(o_m_err), 128'(0));
    chk("rst_data", 128'(o_m_data), 128'(0));
    chk("rst_sel", 128'({o_s_cyc, o_s_stb}), 128'(0));
    chk("rst_stall", 128'(o_m_stall), 128'(0));
    chk("rst_pass", 128'({o_s_we, o_s_addr, o_s_data}), 128'({1'b1, 32'hb000_8000, 32'hcafe_f00d}));
    @(negedge clk);
    reset = 1'b1;
    i_m_cyc = 1'b0; i_m_stb = 1'b0; i_s_ack = 3'b000;
    idle_cycle();

    // Directed scenarios
    txn(32'hb000_0010, 1'b0, 32'h0,          0,  0, -1, 32'hdead_beef);
    idle_cycle();
    txn(32'hb000_8004, 1'b1, 32'h1234_5678,  2,  1, -1, 32'h0);
    idle_cycle();
    txn(32'hc000_0004, 1'b0, 32'h0,          0,  0, -1, 32'hffff_ff41);
    idle_cycle();
    txn(32'ha000_0000, 1'b0, 32'h0,          0,  0, -1, 32'h0);
    idle_cycle();
    txn(32'hb000_0000, 1'b0, 32'h0,          0, -1, -1, 32'h0);
    idle_cycle();
    txn(32'hb000_0020, 1'b0, 32'h0,          0,  2,  2, 32'h1111_2222);
    idle_cycle();
    txn(32'hb000_8020, 1'b0, 32'h0,          1,  3, -1, 32'h5a5a_1234);
    idle_cycle();
    reset_mid();
    // Back-to-back: second strobe lands in the cycle the first ack pulses.
    txn(32'hb000_0040, 1'b0, 32'h0,          0,  1, -1, 32'h0bad_cafe);
    txn(32'hc000_0100, 1'b0, 32'h0,          0,  0, -1, 32'h1234_56aa);
    txn(32'hb000_8100, 1'b0, 32'h0,          0,  2, -1, 32'h7777_8888);
    idle_cycle();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      nst = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0;
      case ($urandom_range(9, 0))
        0:       ack_at = -1;
        1:       ack_at = $urandom_range(TO + 4, 0);
        default: ack_at = $urandom_range(5, 0);
      endcase
      abort_at = ($urandom_range(7, 0) == 0) ? $urandom_range(5, 0) : -1;
      txn(rand_addr(), 1'($urandom), $urandom, nst, ack_at, abort_at, $urandom);
      for (int j = $urandom_range(2, 0); j > 0; j--) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
